// File: rtl/dti_pkg.sv
// Shared sizing helpers and parameter checks for the dti channel blocks.
package dti_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit latency_ok(input int lat);
        return (lat == 0) || (lat == 1);
    endfunction

endpackage

// File: rtl/dti_fifo_mem.sv
// DEPTH x W_DATA register array: synchronous write, asynchronous read.
module dti_fifo_mem #(
    parameter int W_DATA = 64,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [W_DATA-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [W_DATA-1:0] o_rdata
);

    logic [W_DATA-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dti_fifo.sv
// Elastic buffer for the dti valid/ready channel with optional
// combinational bypass when empty (LATENCY=0).
module dti_fifo
    import dti_pkg::*;
#(
    parameter int W_DATA  = 64,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W_DATA-1:0]        din_data,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [W_DATA-1:0]        dout_data,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int PW     = ptr_w(DEPTH);
    localparam int CW     = cnt_w(DEPTH);
    localparam int AW     = PW - 1;
    localparam bit BYPASS = (LATENCY == 0);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("dti_fifo: DEPTH must be a power of two >= 2");
    end
    if (!latency_ok(LATENCY)) begin : g_bad_lat
        $error("dti_fifo: LATENCY must be 0 or 1");
    end

    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic              w_empty;
    logic              w_full;
    logic              w_byp;
    logic              w_push;
    logic              w_pop;
    logic              w_wr;
    logic              w_rd;
    logic [W_DATA-1:0] w_rdata;
    logic [PW-1:0]     w_diff;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0])
                  && (r_wptr[AW] != r_rptr[AW]);
    assign w_diff  = r_wptr - r_rptr;
    assign count   = CW'(w_diff);

    assign w_byp      = BYPASS && w_empty;
    assign din_ready  = !w_full;
    assign dout_valid = w_byp ? din_valid : !w_empty;
    assign dout_data  = w_byp ? din_data : w_rdata;

    assign w_push = din_valid && din_ready;
    assign w_pop  = dout_valid && dout_ready;
    // A bypassed word that is taken immediately never touches storage.
    assign w_wr   = w_push && !(w_byp && dout_ready);
    assign w_rd   = w_pop && !w_byp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    dti_fifo_mem #(
        .W_DATA (W_DATA),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr && rst),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (din_data),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

endmodule

// File: doc/dti_fifo.md
# dti_fifo

Parametrised elastic buffer for the dti valid/ready channel. It decouples a producer from a consumer with `DEPTH` entries of storage and a selectable bypass mode, and it reports occupancy. It sits between any two dti endpoints where back-pressure must be absorbed or combinational ready paths must be cut. It is the first dti block with storage and occupancy reporting.

## Interface
Parameters:
- `W_DATA`, 64: payload width in bits, ≥1.
- `DEPTH`, 4: number of entries; a power of two, ≥2.
- `LATENCY`, 1: mode select.
  - 1: registered output; first-word latency of 1 cycle.
  - 0: combinational bypass when the FIFO is empty.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `din_data`  in  W_DATA: input payload.
- `din_valid`  in  1: input payload valid.
- `din_ready`  out  1: the FIFO accepts `din` this cycle.
- `dout_data`  out  W_DATA: output payload.
- `dout_valid`  out  1: output payload valid.
- `dout_ready`  in  1: the downstream accepts `dout` this cycle.
- `count`  out  $clog2(DEPTH+1): number of stored entries (0..DEPTH).

## Operation
- Handshakes:
  - Push occurs when `din_valid && din_ready`.
  - Pop occurs when `dout_valid && dout_ready`.
- `din_ready = (count != DEPTH)`. It is a function of state only and has no combinational path from `dout_ready`.
- Storage is a circular buffer with read and write pointers of width $clog2(DEPTH)+1. The extra MSB is the wrap bit.
  - Empty: pointers fully equal.
  - Full: pointers have the same index bits and different MSBs.
  - Pointers wrap modulo 2·DEPTH. Each increment is +1 with natural overflow.
- `count` is the write pointer minus the read pointer, modulo 2·DEPTH.
- `dout_data` is the entry at the read pointer. `dout_valid = (count != 0)`.
- LATENCY=0, empty FIFO:
  - `dout_valid = din_valid` and `dout_data = din_data`.
  - If `dout_ready=1`, the word is consumed without being stored. Pointers and `count` are unchanged.
  - If `dout_ready=0`, the word is stored normally.
- Once `dout_valid` is asserted, `dout_data` is held stable until the pop. Producers must likewise hold `din_data` until their push.
- Simultaneous push and pop when 0 < count < DEPTH: both pointers advance and `count` is unchanged.
- Push while full cannot occur, because `din_ready=0`.
- Pop while empty cannot occur in LATENCY=1, because `dout_valid=0`.

## Timing
- Reset (`rst=0` at a rising edge):
  - Pointers are cleared and `count=0`.
  - `din_ready=1` from the first cycle after reset.
  - `dout_valid=0` (for LATENCY=0, until `din_valid` is seen).
  - Storage contents are not reset; `dout_data` is don't-care while `dout_valid=0`.
- Reset mid-operation: all stored words are discarded. A handshake coinciding with the reset edge has no effect on state.
- Latency:
  - LATENCY=1: a push at edge N gives `dout_valid=1` in cycle N+1.
  - LATENCY=0, empty FIFO: the output is visible in the same cycle as the input.
- Throughput: one word per cycle in steady state for any `DEPTH`.
- After a pop at full, `din_ready` rises in the next cycle. This gives one cycle of ready bubble when full, which is the cost of having no combinational path.
- `count` updates on the edge after the push or pop.

## Structure
- Shared package `dti_pkg`:
  - Function `cnt_w(depth)` returning $clog2(depth+1).
  - Function `ptr_w(depth)` returning $clog2(depth)+1.
  - Localparam checks: `DEPTH` is a power of two and ≥2, and `LATENCY` is in {0,1}. Violations raise elaboration `$error`.
- One sub-module, `dti_fifo_mem`: DEPTH×W_DATA register array with one synchronous write port and one asynchronous read port.
- The top level holds the pointers, full/empty logic and the bypass multiplexer.
- Ports of the top level map one-to-one onto dti consumer (`din_*`) and producer (`dout_*`) modports.

## Test plan
- **Reset:** hold `rst=0` for 3 cycles with `din_valid=1`.
  - Required: `din_ready=1`, `dout_valid=0` (LATENCY=1), `count=0`.
- **Fill/drain:** `DEPTH=4`, `dout_ready=0`, push 0x11, 0x22, 0x33, 0x44.
  - Required: `count` reads 1, 2, 3, 4; `din_ready=0` at count 4.
  - Then `dout_ready=1`: out 0x11..0x44 in order; `count` reads 3..0; `din_ready` returns 1 the cycle after the first pop.
- **Streaming:** `din_valid=1` and `dout_ready=1` continuously, pushing 0..99.
  - Required: out 0..99 in order, one per cycle after a 1-cycle start, `count` stable at 1.
- **Wrap-around:** `DEPTH=4`, 10 rounds of push 3 / pop 3.
  - Required: pointers wrap, data order is preserved, full/empty are correct.
- **Bypass:** LATENCY=0, empty FIFO, `din=0xAB` with `din_valid=1` and `dout_ready=1`.
  - Required: `dout_valid=1` and `dout_data=0xAB` in the same cycle; `count` stays 0.
  - With `dout_ready=0`: `count` becomes 1 and 0xAB is held on `dout`.
- **Mid-operation reset:** with `count=3`, assert `rst=0` for 1 cycle.
  - Required: `count=0` and `dout_valid=0` next cycle; old data is never emitted.
